// File: rtl/replay_pkg.sv
// Shared types and sizing helpers for the replay unpack buffer.
package replay_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int P_DEF         = 64;
  localparam int GAMMA_LEN_DEF = 16;

  // Counter must hold 0..GAMMA_LEN inclusive (it saturates at GAMMA_LEN).
  function automatic int idx_w(input int gamma_len);
    return $clog2(gamma_len + 1);
  endfunction

endpackage

// File: rtl/replay_unpack_bank.sv
// One stream's ping-pong storage: two banks of SLOT_LEN x P spike words.
// The write bank can be wiped on a swap while entry wr_addr is written
// on the same edge; the read port is combinational from the other bank.
module replay_unpack_bank #(
  parameter int P        = 64,
  parameter int SLOT_LEN = 8,
  parameter int AW       = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [P-1:0]  wr_data,
  input  logic          clr,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [P-1:0]  rd_data
);

  logic [P-1:0] mem_q [2][SLOT_LEN];
  logic [P-1:0] mem_d [2][SLOT_LEN];

  // Next bank contents: optional wipe of the write bank, then the write wins.
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int e = 0; e < SLOT_LEN; e++) begin
        mem_d[wr_bank][e] = '0;
      end
    end
    if (wr_en) begin
      mem_d[wr_bank][wr_addr] = wr_data;
    end
  end

  // Bank storage; reset discards any partially filled frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int e = 0; e < SLOT_LEN; e++) begin
          mem_q[b][e] <= '0;
        end
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_bank][rd_addr];

endmodule

// File: rtl/replay_unpack_buffer.sv
// Receive end of the replay path. Captures the multiplexed column output
// (stream0 in the first half-gamma, stream1 in the second) into per-stream
// ping-pong banks and replays both streams one gamma later, each at native
// rate (samples on even indices, zero on odd indices).
module replay_unpack_buffer
  import replay_pkg::*;
#(
  parameter int P         = P_DEF,
  parameter int GAMMA_LEN = GAMMA_LEN_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         gamma_start,
  input  logic [P-1:0] mux_in,
  output logic [P-1:0] out0,
  output logic [P-1:0] out1,
  output logic         out_valid,
  output logic         gamma_err
);

  localparam int SLOT_LEN = GAMMA_LEN / 2;
  localparam int CW       = idx_w(GAMMA_LEN);
  localparam int AW       = $clog2(SLOT_LEN);

  localparam logic [CW-1:0] GL = CW'(GAMMA_LEN);
  localparam logic [CW-1:0] SL = CW'(SLOT_LEN);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          late_seen_q, late_seen_d;
  logic [P-1:0]  out0_q, out0_d;
  logic [P-1:0]  out1_q, out1_d;
  logic          out_valid_q, out_valid_d;
  logic          gamma_err_q, gamma_err_d;

  logic [CW-1:0] idx;
  logic          wr_eff, rd_eff;
  logic          in_frame, cap_en, in_s0;
  logic          we0, we1;
  logic [AW-1:0] wr_addr0, wr_addr1, rd_addr;
  logic [P-1:0]  rd0, rd1;
  logic          early, late;

  // Frame position, bank selection and capture enables for this clock.
  always_comb begin
    idx      = gamma_start ? '0 : cnt_q;
    wr_eff   = gamma_start ? ~wr_bank_q : wr_bank_q;
    rd_eff   = ~wr_eff;
    in_frame = (idx < GL);
    in_s0    = (idx < SL);
    // A gamma_start in IDLE already captures index 0 of the first frame.
    cap_en   = ((state_q != IDLE) || gamma_start) && in_frame;
    we0      = cap_en && in_s0;
    we1      = cap_en && !in_s0;
    wr_addr0 = AW'(idx);
    wr_addr1 = AW'(idx - SL);
    rd_addr  = AW'(idx >> 1);
  end

  // Next-state, counter, error and replay output logic.
  always_comb begin
    state_d = state_q;
    if (gamma_start) begin
      case (state_q)
        IDLE:    state_d = FILL;
        FILL:    state_d = RUN;
        default: state_d = RUN;
      endcase
    end

    if (gamma_start) begin
      cnt_d = CW'(1);
    end else if (cnt_q == GL) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    wr_bank_d = wr_eff;

    // Early: new frame before the old one completed. Late: a clock past the
    // frame end with no gamma_start, flagged once until the next start.
    early       = gamma_start && (state_q != IDLE) && (cnt_q < GL);
    late        = !gamma_start && (state_q != IDLE) && (cnt_q == GL) && !late_seen_q;
    gamma_err_d = early || late;
    late_seen_d = gamma_start ? 1'b0 : (late_seen_q || late);

    out0_d = '0;
    out1_d = '0;
    if ((state_d == RUN) && in_frame && !idx[0]) begin
      out0_d = rd0;
      out1_d = rd1;
    end
    out_valid_d = (state_d == RUN);
  end

  // Control FSM, frame counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_bank_q   <= 1'b0;
      late_seen_q <= 1'b0;
      out0_q      <= '0;
      out1_q      <= '0;
      out_valid_q <= 1'b0;
      gamma_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_bank_q   <= wr_bank_d;
      late_seen_q <= late_seen_d;
      out0_q      <= out0_d;
      out1_q      <= out1_d;
      out_valid_q <= out_valid_d;
      gamma_err_q <= gamma_err_d;
    end
  end

  replay_unpack_bank #(.P(P), .SLOT_LEN(SLOT_LEN), .AW(AW)) u_bank_s0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (we0),
    .wr_bank (wr_eff),
    .wr_addr (wr_addr0),
    .wr_data (mux_in),
    .clr     (gamma_start),
    .rd_bank (rd_eff),
    .rd_addr (rd_addr),
    .rd_data (rd0)
  );

  replay_unpack_bank #(.P(P), .SLOT_LEN(SLOT_LEN), .AW(AW)) u_bank_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (we1),
    .wr_bank (wr_eff),
    .wr_addr (wr_addr1),
    .wr_data (mux_in),
    .clr     (gamma_start),
    .rd_bank (rd_eff),
    .rd_addr (rd_addr),
    .rd_data (rd1)
  );

  assign out0      = out0_q;
  assign out1      = out1_q;
  assign out_valid = out_valid_q;
  assign gamma_err = gamma_err_q;

endmodule
